// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolve signals of the branch predictor.
// The master modport is the pipeline; the slave modport is the predictor itself.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            clear_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            res_valid_i;
  logic [XLEN-1:0] res_pc_i;
  logic [1:0]      res_kind_i;
  logic            res_taken_i;
  logic [XLEN-1:0] res_target_i;
  logic            res_pred_taken_i;
  logic [XLEN-1:0] res_pred_target_i;
  logic            mispredict_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output clear_i, fetch_pc_i, res_valid_i, res_pc_i, res_kind_i, res_taken_i,
           res_target_i, res_pred_taken_i, res_pred_target_i,
    input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o
  );

  modport slave (
    input  clear_i, fetch_pc_i, res_valid_i, res_pc_i, res_kind_i, res_taken_i,
           res_target_i, res_pred_taken_i, res_pred_target_i,
    output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters plus resolve-side flush/redirect.
// Define BP_RAS_EN to add a circular return address stack for jalr returns.
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_BITS  = 2,
  parameter int RAS_DEPTH = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  branch_predictor_if.slave  bus
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);
  localparam logic [1:0] KIND_COND = 2'd0;
  localparam logic [1:0] KIND_CALL = 2'd2;
  localparam logic [1:0] KIND_RET  = 2'd3;

  logic [ENTRIES-1:0]  r_valid;
  logic [TAGW-1:0]     r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt    [ENTRIES];
  logic [1:0]          r_kind   [ENTRIES];

  logic [IDX-1:0]  w_fIdx;
  logic [IDX-1:0]  w_rIdx;
  logic [TAGW-1:0] w_fTag;
  logic [TAGW-1:0] w_rTag;
  logic            w_fHit;
  logic            w_rHit;
  logic            w_fTaken;
  logic [XLEN-1:0] w_fPcPlus4;
  logic [XLEN-1:0] w_rPcPlus4;
  logic            w_useRas;
  logic [XLEN-1:0] w_rasTop;

  assign w_fIdx     = bus.fetch_pc_i[IDX+1:2];
  assign w_fTag     = bus.fetch_pc_i[XLEN-1:IDX+2];
  assign w_rIdx     = bus.res_pc_i[IDX+1:2];
  assign w_rTag     = bus.res_pc_i[XLEN-1:IDX+2];
  assign w_fPcPlus4 = bus.fetch_pc_i + XLEN'(4);
  assign w_rPcPlus4 = bus.res_pc_i + XLEN'(4);
  assign w_fHit     = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
  assign w_rHit     = r_valid[w_rIdx] && (r_tag[w_rIdx] == w_rTag);
  assign w_fTaken   = w_fHit && ((r_kind[w_fIdx] != KIND_COND) || r_cnt[w_fIdx][CNT_BITS-1]);

`ifdef BP_RAS_EN
  localparam int RIDX = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RCW  = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [RIDX-1:0] r_rasTop;
  logic [RCW-1:0]  r_rasCnt;
  logic [RIDX-1:0] w_rasNext;

  assign w_rasNext = r_rasTop + RIDX'(1);
  assign w_rasTop  = r_ras[r_rasTop];
  assign w_useRas  = (r_kind[w_fIdx] == KIND_RET) && (r_rasCnt != '0);

  // Calls push their return address; when full the oldest slot is simply overwritten.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rasTop <= '0;
      r_rasCnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (bus.clear_i) begin
      r_rasCnt <= '0;
    end else if (bus.res_valid_i) begin
      if (bus.res_kind_i == KIND_CALL) begin
        r_rasTop         <= w_rasNext;
        r_ras[w_rasNext] <= w_rPcPlus4;
        if (r_rasCnt != RCW'(RAS_DEPTH)) begin
          r_rasCnt <= r_rasCnt + RCW'(1);
        end
      end else if ((bus.res_kind_i == KIND_RET) && (r_rasCnt != '0)) begin
        r_rasTop <= r_rasTop - RIDX'(1);
        r_rasCnt <= r_rasCnt - RCW'(1);
      end
    end
  end
`else
  localparam int unusedRasDepth = RAS_DEPTH;

  assign w_useRas = 1'b0;
  assign w_rasTop = '0;
`endif

  always_comb begin
    bus.pred_taken_o  = w_fTaken;
    bus.pred_target_o = w_fPcPlus4;
    if (w_fTaken) begin
      bus.pred_target_o = w_useRas ? w_rasTop : r_target[w_fIdx];
    end
  end

  // Flush decision is purely from the resolve slot; held quiet while in reset.
  always_comb begin
    bus.mispredict_o  = 1'b0;
    bus.redirect_pc_o = '0;
    if (rst_ni && bus.res_valid_i) begin
      bus.mispredict_o  = (bus.res_taken_i != bus.res_pred_taken_i) ||
                          (bus.res_taken_i && (bus.res_target_i != bus.res_pred_target_i));
      bus.redirect_pc_o = bus.res_taken_i ? bus.res_target_i : w_rPcPlus4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
        r_kind[i]   <= '0;
      end
    end else if (bus.clear_i) begin
      r_valid <= '0;
    end else if (bus.res_valid_i) begin
      if (w_rHit) begin
        if (bus.res_kind_i == KIND_COND) begin
          if (bus.res_taken_i) begin
            r_target[w_rIdx] <= bus.res_target_i;
            if (r_cnt[w_rIdx] != CNT_MAX) begin
              r_cnt[w_rIdx] <= r_cnt[w_rIdx] + CNT_BITS'(1);
            end
          end else if (r_cnt[w_rIdx] != '0) begin
            r_cnt[w_rIdx] <= r_cnt[w_rIdx] - CNT_BITS'(1);
          end
        end else begin
          r_target[w_rIdx] <= bus.res_target_i;
          r_kind[w_rIdx]   <= bus.res_kind_i;
        end
      end else if (bus.res_taken_i) begin
        r_valid[w_rIdx]  <= 1'b1;
        r_tag[w_rIdx]    <= w_rTag;
        r_target[w_rIdx] <= bus.res_target_i;
        r_cnt[w_rIdx]    <= CNT_WT;
        r_kind[w_rIdx]   <= bus.res_kind_i;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed test-plan sequences plus random traffic,
// checked against a whole-PC behavioural model (RAS sequence only when BP_RAS_EN is defined).
module tb_branch_predictor;
  localparam int XLEN      = 32;
  localparam int ENTRIES   = 16;
  localparam int CNT_BITS  = 2;
  localparam int RAS_DEPTH = 4;
  localparam int CNT_HALF  = 1 << (CNT_BITS - 1);
  localparam int CNT_TOP   = (1 << CNT_BITS) - 1;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  branch_predictor_if #(.XLEN(XLEN)) bpIf ();

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_BITS(CNT_BITS), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk_i (clock),
    .rst_ni(resetN),
    .bus   (bpIf.slave)
  );

  typedef struct {
    logic            predTaken;
    logic [XLEN-1:0] predTarget;
    logic            mispredict;
    logic [XLEN-1:0] redirectPc;
  } expect_t;

  expect_t expQ[$];
  int passCount  = 0;
  int checkCount = 0;

  bit              mValid  [ENTRIES];
  logic [XLEN-1:0] mPc     [ENTRIES];
  logic [XLEN-1:0] mTarget [ENTRIES];
  int              mCnt    [ENTRIES];
  int              mKind   [ENTRIES];
  logic [XLEN-1:0] mRas[$];
  bit              mInReset = 1'b1;

  function automatic int idxOf(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < ENTRIES; k++) begin
      mValid[k]  = 1'b0;
      mPc[k]     = '0;
      mTarget[k] = '0;
      mCnt[k]    = CNT_HALF - 1;
      mKind[k]   = 0;
    end
    mRas.delete();
  endfunction

  // A resident branch hits only when its whole word address matches the fetched PC.
  function automatic void predict(input logic [XLEN-1:0] pc, output logic taken,
                                  output logic [XLEN-1:0] tgt);
    int i   = idxOf(pc);
    bit hit = mValid[i] && (mPc[i][XLEN-1:2] == pc[XLEN-1:2]);
    taken = hit && (mKind[i] != 0 || mCnt[i] >= CNT_HALF);
    tgt   = pc + XLEN'(4);
    if (taken) begin
      tgt = mTarget[i];
`ifdef BP_RAS_EN
      if (mKind[i] == 3 && mRas.size() > 0) tgt = mRas[$];
`endif
    end
  endfunction

  function automatic void modelUpdate(input logic v, input logic [XLEN-1:0] pc,
                                      input logic [1:0] kind, input logic taken,
                                      input logic [XLEN-1:0] tgt, input logic clr);
    int i = idxOf(pc);
    bit hit;
    if (clr) begin
      for (int k = 0; k < ENTRIES; k++) mValid[k] = 1'b0;
      mRas.delete();
      return;
    end
    if (!v) return;
    hit = mValid[i] && (mPc[i][XLEN-1:2] == pc[XLEN-1:2]);
    if (hit && kind == 0) begin
      if (taken) begin
        mCnt[i]    = (mCnt[i] == CNT_TOP) ? CNT_TOP : mCnt[i] + 1;
        mTarget[i] = tgt;
      end else begin
        mCnt[i] = (mCnt[i] == 0) ? 0 : mCnt[i] - 1;
      end
    end else if (hit) begin
      mTarget[i] = tgt;
      mKind[i]   = int'(kind);
    end else if (taken) begin
      mValid[i]  = 1'b1;
      mPc[i]     = pc;
      mTarget[i] = tgt;
      mCnt[i]    = CNT_HALF;
      mKind[i]   = int'(kind);
    end
`ifdef BP_RAS_EN
    if (kind == 2) begin
      mRas.push_back(pc + XLEN'(4));
      if (mRas.size() > RAS_DEPTH) void'(mRas.pop_front());
    end else if (kind == 3 && mRas.size() > 0) begin
      void'(mRas.pop_back());
    end
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive one cycle of stimulus, queue its expected response, then mirror the clock edge.
  task automatic applyStimulus(input logic [XLEN-1:0] fetchPc, input logic resValid,
                               input logic [XLEN-1:0] resPc, input logic [1:0] resKind,
                               input logic resTaken, input logic [XLEN-1:0] resTarget,
                               input logic resPredTaken, input logic [XLEN-1:0] resPredTarget,
                               input logic clear);
    expect_t e;
    logic pt;
    logic [XLEN-1:0] ptg;
    bpIf.fetch_pc_i        = fetchPc;
    bpIf.res_valid_i       = resValid;
    bpIf.res_pc_i          = resPc;
    bpIf.res_kind_i        = resKind;
    bpIf.res_taken_i       = resTaken;
    bpIf.res_target_i      = resTarget;
    bpIf.res_pred_taken_i  = resPredTaken;
    bpIf.res_pred_target_i = resPredTarget;
    bpIf.clear_i           = clear;
    predict(fetchPc, pt, ptg);
    e.predTaken  = pt;
    e.predTarget = ptg;
    e.mispredict = 1'b0;
    e.redirectPc = '0;
    if (!mInReset && resValid) begin
      e.mispredict = (resTaken != resPredTaken) || (resTaken && resTarget != resPredTarget);
      e.redirectPc = resTaken ? resTarget : resPc + XLEN'(4);
    end
    expQ.push_back(e);
    @(posedge clock);
    if (!mInReset) modelUpdate(resValid, resPc, resKind, resTaken, resTarget, clear);
    #1;
  endtask

  task automatic fetchCycle(input logic [XLEN-1:0] pc);
    applyStimulus(pc, 1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic resolveCycle(input logic [XLEN-1:0] fetchPc, input logic [XLEN-1:0] pc,
                              input logic [1:0] kind, input logic taken,
                              input logic [XLEN-1:0] tgt, input logic pTaken,
                              input logic [XLEN-1:0] pTarget);
    applyStimulus(fetchPc, 1'b1, pc, kind, taken, tgt, pTaken, pTarget, 1'b0);
  endtask

  function automatic logic [XLEN-1:0] pickPc();
    int r = int'($urandom_range(0, 9));
    logic [XLEN-1:0] pc;
    if (r < 8) pc = (($urandom_range(0, 1) != 0) ? 32'h400 : 32'h0) + ($urandom_range(0, 31) << 2);
    else if (r == 8) pc = 32'hFFFF_FFFC;
    else pc = $urandom() & ~32'h3;
    return pc;
  endfunction

  task automatic randomCycle();
    logic [XLEN-1:0] resPc = pickPc();
    logic [1:0]      kind  = 2'($urandom_range(0, 3));
    logic            taken = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
    logic            pt;
    logic [XLEN-1:0] ptg;
    if ($urandom_range(0, 1) != 0) predict(resPc, pt, ptg);
    else begin
      pt  = 1'($urandom_range(0, 1));
      ptg = pickPc();
    end
    applyStimulus(pickPc(), 1'($urandom_range(0, 1)), resPc, kind, taken, pickPc(), pt, ptg,
                  ($urandom_range(0, 31) == 0));
  endtask

  always begin
    @(negedge clock);
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput("pred_taken", XLEN'(bpIf.pred_taken_o), XLEN'(e.predTaken));
      checkOutput("pred_target", bpIf.pred_target_o, e.predTarget);
      checkOutput("mispredict", XLEN'(bpIf.mispredict_o), XLEN'(e.mispredict));
      checkOutput("redirect_pc", bpIf.redirect_pc_o, e.redirectPc);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    bpIf.clear_i = 1'b0;
    bpIf.res_valid_i = 1'b0;
    @(posedge clock);
    #1;
    // In reset: resolve slot is busy with a wrong prediction, yet outputs must stay quiet.
    applyStimulus(32'h100, 1'b1, 32'h2F0, 2'd0, 1'b1, 32'h300, 1'b0, '0, 1'b0);
    applyStimulus(32'h100, 1'b1, 32'h200, 2'd1, 1'b1, 32'h180, 1'b0, '0, 1'b0);
    resetN   = 1'b1;
    mInReset = 1'b0;
    fetchCycle(32'h100);

    resolveCycle(32'h200, 32'h200, 2'd0, 1'b1, 32'h180, 1'b0, 32'h204);
    fetchCycle(32'h200);
    resolveCycle(32'h200, 32'h200, 2'd0, 1'b0, 32'h180, 1'b1, 32'h180);
    resolveCycle(32'h200, 32'h200, 2'd0, 1'b0, 32'h180, 1'b1, 32'h180);
    fetchCycle(32'h200);
    for (int n = 0; n < 4; n++) resolveCycle(32'h200, 32'h200, 2'd0, 1'b1, 32'h180, 1'b0, 32'h204);
    resolveCycle(32'h200, 32'h200, 2'd0, 1'b0, 32'h180, 1'b1, 32'h180);
    fetchCycle(32'h200);

    resolveCycle(32'h2F0, 32'h2F0, 2'd0, 1'b1, 32'h300, 1'b0, 32'h2F4);
    resolveCycle(32'h2F0, 32'h2F0, 2'd0, 1'b1, 32'h308, 1'b1, 32'h300);
    resolveCycle(32'h2F0, 32'h2F0, 2'd0, 1'b1, 32'h308, 1'b1, 32'h308);

    applyStimulus(32'h040, 1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0, 1'b1);
    resolveCycle(32'h040, 32'h040, 2'd0, 1'b1, 32'h500, 1'b0, 32'h044);
    fetchCycle(32'h040);
    resolveCycle(32'h440, 32'h440, 2'd0, 1'b1, 32'h600, 1'b0, 32'h444);
    fetchCycle(32'h040);
    fetchCycle(32'h440);

    applyStimulus(32'h200, 1'b1, 32'h700, 2'd1, 1'b1, 32'h780, 1'b0, 32'h704, 1'b1);
    fetchCycle(32'h200);
    fetchCycle(32'h700);
    fetchCycle(32'h440);

    fetchCycle(32'hFFFF_FFFC);
    resolveCycle(32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);

`ifdef BP_RAS_EN
    applyStimulus(32'h83C, 1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0, 1'b1);
    resolveCycle(32'h83C, 32'h83C, 2'd3, 1'b1, 32'h900, 1'b0, 32'h840);
    for (int n = 1; n <= 5; n++) begin
      resolveCycle(32'h83C, XLEN'(n * 16), 2'd2, 1'b1, 32'h1000, 1'b1, 32'h1000);
    end
    for (int n = 0; n < 5; n++) resolveCycle(32'h83C, 32'h83C, 2'd3, 1'b1, 32'h900, 1'b1, 32'h900);
    fetchCycle(32'h83C);
`endif

    for (int n = 0; n < 400; n++) randomCycle();

    resetN   = 1'b0;
    mInReset = 1'b1;
    modelReset();
    for (int n = 0; n < 2; n++) randomCycle();
    resetN   = 1'b1;
    mInReset = 1'b0;
    fetchCycle(32'h200);
    for (int n = 0; n < 150; n++) randomCycle();

    @(negedge clock);
    #1;
    checkOutput("scoreboard_drain", XLEN'(expQ.size()), '0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction unit that supersedes the purely resolve-side branch logic. It is a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. The fetch stage queries it combinationally every cycle. The execute stage feeds back resolved outcomes, from which the block updates its tables and raises a mispredict flush with the correct redirect PC. An optional return address stack (RAS) predicts `jalr` returns.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `ENTRIES`, 16, BTB entries; power of two, ≥2. `IDX = $clog2(ENTRIES)`.
- `CNT_BITS`, 2, direction counter width; ≥1.
- `RAS_DEPTH`, 4, RAS entries; power of two. Used only with `BP_RAS_EN`.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous invalidate of all BTB valid bits and RAS count.
- `fetch_pc_i` in XLEN: PC being fetched.
- `pred_taken_o` out 1: predict taken.
- `pred_target_o` out XLEN: predicted target. Equals `fetch_pc_i+4` when not taken.
- `res_valid_i` in 1: resolve slot holds a control-flow instruction.
- `res_pc_i` in XLEN: its PC.
- `res_kind_i` in 2: 0 = cond branch, 1 = jal, 2 = jalr call (rd=x1), 3 = jalr other/return.
- `res_taken_i` in 1: actual direction (1 for kinds 1–3).
- `res_target_i` in XLEN: actual target, bit 0 already cleared.
- `res_pred_taken_i` in 1: prediction carried down the pipe.
- `res_pred_target_i` in XLEN: prediction carried down the pipe.
- `mispredict_o` out 1: flush younger instructions.
- `redirect_pc_o` out XLEN: fetch restart PC.

## Operation
- Entry fields: `valid`, `tag = pc[XLEN-1:IDX+2]`, `target[XLEN-1:0]`, `cnt[CNT_BITS-1:0]`, `kind[1:0]`. Index is `pc[IDX+1:2]`.
- Lookup (combinational):
  - `hit = valid & tag match`.
  - `pred_taken_o = hit & (kind != 0 | cnt[MSB])`.
  - Target is the entry target, or the RAS top (see Configuration).
- Mispredict (combinational, gated by `res_valid_i`):
  - `mispredict_o = (res_taken_i != res_pred_taken_i) | (res_taken_i & res_target_i != res_pred_target_i)`.
  - `redirect_pc_o = res_taken_i ? res_target_i : res_pc_i+4`. Output is 0 when not valid.
- Update at the clock edge when `res_valid_i` is high:
  - Hit, kind 0: counter increments if taken, decrements if not, saturating at 0 and `2^CNT_BITS-1`. Target is rewritten if taken.
  - Hit, kind ≠ 0: target and kind are rewritten.
  - Miss and taken: the entry is allocated and overwrites any victim. `cnt = 2^(CNT_BITS-1)` (weakly taken).
  - Miss and not taken: no allocation.
- Arithmetic: all PC+4 additions are modulo 2^XLEN, so PC 0xFFFF_FFFC+4 = 0.

## Timing
- Lookup has zero latency. Updates are visible to lookups on the cycle after the resolve edge.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents. There is no bypass.
- `clear_i` together with `res_valid_i`: clear wins, and no allocation happens that cycle.
- Reset (asynchronous, at any time, including mid-update):
  - All `valid` bits = 0.
  - All `cnt = 2^(CNT_BITS-1)-1` (weakly not-taken).
  - Targets = 0; RAS pointer/count = 0.
  - Outputs: `pred_taken_o` = 0, `pred_target_o = fetch_pc_i+4`, `mispredict_o` = 0, `redirect_pc_o` = 0.

## Configuration
- `BP_RAS_EN` defined:
  - A circular RAS of `RAS_DEPTH` entries is built.
  - Resolve of kind 2 pushes `res_pc_i+4`. When full, the push overwrites the oldest entry and the count saturates at `RAS_DEPTH`.
  - Resolve of kind 3 pops. A pop when empty is ignored.
  - A BTB hit with kind 3 and count > 0 predicts the RAS top; with count = 0 it falls back to the entry target.
  - `clear_i` zeroes the count.
- `BP_RAS_EN` undefined: no RAS storage; kind 3 always uses the BTB target. `RAS_DEPTH` is ignored.

## Test plan
- **Reset:** after reset, any PC, e.g. 0x100 → `pred_taken_o` = 0, `pred_target_o` = 0x104.
- **Counter training:**
  - Resolve cond branch at 0x200 taken to 0x180 once → next cycle fetch 0x200 predicts taken, target 0x180.
  - Two not-taken resolves → predicts not taken, target 0x204.
  - Three more taken resolves leave cnt saturated at 3.
- **Mispredict:**
  - Resolve pred_taken=0, taken=1, target 0x300 at pc 0x2F0 → `mispredict_o` = 1, redirect 0x300.
  - Pred taken to 0x300 but actual 0x308 → mispredict, redirect 0x308.
  - Correct prediction → `mispredict_o` = 0.
- **Aliasing (ENTRIES=16):** install 0x040, then resolve taken 0x440 (same index, different tag) → fetch 0x040 misses, fetch 0x440 hits.
- **Same-cycle hazard:** fetch 0x200 while resolving first allocation of 0x200 → that cycle not taken; next cycle taken. Asserting `clear_i` → all lookups miss.
- **RAS (`BP_RAS_EN`, depth 4):**
  - Five calls from 0x10, 0x20, 0x30, 0x40, 0x50 → ret entry predicts 0x54, 0x44, 0x34, 0x24, then falls back to the BTB target.
